// File: rtl/zx_ps2_keymatrix_pkg.sv
// Shared types, scancode constants and scancode-to-matrix mapping for the
// PS/2 to ZX Spectrum keyboard matrix bridge.
package zx_kbd_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    typedef struct packed {
        logic       valid;
        logic [2:0] row;
        logic [2:0] col;
    } key_pos_t;

    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_F0     = 8'hF0;
    localparam logic [7:0] SC_ALT    = 8'h11;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_RIGHT  = 8'h74;

    // Returns n for function key Fn, 0 for anything else.
    function automatic logic [3:0] sc_to_fn(input logic ext, input logic [7:0] code);
        logic [3:0] n;
        n = 4'd0;
        if (!ext) begin
            case (code)
                8'h05: n = 4'd1;
                8'h06: n = 4'd2;
                8'h04: n = 4'd3;
                8'h0C: n = 4'd4;
                8'h03: n = 4'd5;
                8'h0B: n = 4'd6;
                8'h83: n = 4'd7;
                8'h0A: n = 4'd8;
                8'h01: n = 4'd9;
                8'h09: n = 4'd10;
                8'h78: n = 4'd11;
                default: n = 4'd0;
            endcase
        end
        return n;
    endfunction

    function automatic key_pos_t sc_to_pos(input logic ext, input logic [7:0] code);
        key_pos_t p;
        p = '0;
        if (!ext) begin
            case (code)
                8'h1A: p = {1'b1, 3'd0, 3'd1};
                8'h22: p = {1'b1, 3'd0, 3'd2};
                8'h21: p = {1'b1, 3'd0, 3'd3};
                8'h2A: p = {1'b1, 3'd0, 3'd4};
                8'h1C: p = {1'b1, 3'd1, 3'd0};
                8'h1B: p = {1'b1, 3'd1, 3'd1};
                8'h23: p = {1'b1, 3'd1, 3'd2};
                8'h2B: p = {1'b1, 3'd1, 3'd3};
                8'h34: p = {1'b1, 3'd1, 3'd4};
                8'h15: p = {1'b1, 3'd2, 3'd0};
                8'h1D: p = {1'b1, 3'd2, 3'd1};
                8'h24: p = {1'b1, 3'd2, 3'd2};
                8'h2D: p = {1'b1, 3'd2, 3'd3};
                8'h2C: p = {1'b1, 3'd2, 3'd4};
                8'h16: p = {1'b1, 3'd3, 3'd0};
                8'h1E: p = {1'b1, 3'd3, 3'd1};
                8'h26: p = {1'b1, 3'd3, 3'd2};
                8'h25: p = {1'b1, 3'd3, 3'd3};
                8'h2E: p = {1'b1, 3'd3, 3'd4};
                8'h45: p = {1'b1, 3'd4, 3'd0};
                8'h46: p = {1'b1, 3'd4, 3'd1};
                8'h3E: p = {1'b1, 3'd4, 3'd2};
                8'h3D: p = {1'b1, 3'd4, 3'd3};
                8'h36: p = {1'b1, 3'd4, 3'd4};
                8'h4D: p = {1'b1, 3'd5, 3'd0};
                8'h44: p = {1'b1, 3'd5, 3'd1};
                8'h43: p = {1'b1, 3'd5, 3'd2};
                8'h3C: p = {1'b1, 3'd5, 3'd3};
                8'h35: p = {1'b1, 3'd5, 3'd4};
                8'h5A: p = {1'b1, 3'd6, 3'd0};
                8'h4B: p = {1'b1, 3'd6, 3'd1};
                8'h42: p = {1'b1, 3'd6, 3'd2};
                8'h3B: p = {1'b1, 3'd6, 3'd3};
                8'h33: p = {1'b1, 3'd6, 3'd4};
                8'h29: p = {1'b1, 3'd7, 3'd0};
                8'h3A: p = {1'b1, 3'd7, 3'd2};
                8'h31: p = {1'b1, 3'd7, 3'd3};
                8'h32: p = {1'b1, 3'd7, 3'd4};
                default: p = '0;
            endcase
        end
        return p;
    endfunction

endpackage

// File: rtl/zx_ps2_keymatrix_if.sv
// Received-byte stream from the PS/2 frame receiver to the matrix decoder.
// rx_valid is a one-cycle strobe with rx_byte stable while it is high; there is
// no ready, the decoder accepts every byte in the cycle it is offered.
interface zx_ps2_keymatrix_if;
    logic [7:0] rx_byte;
    logic       rx_valid;

    modport master (output rx_byte, output rx_valid);
    modport slave  (input  rx_byte, input  rx_valid);
endinterface

// File: rtl/zx_ps2_keymatrix_ps2_rx.sv
// PS/2 device-to-host frame receiver: synchroniser, falling-edge detect,
// 11-bit frame FSM with odd-parity/stop checking and an inter-bit watchdog.
module ps2_rx
    import zx_kbd_pkg::*;
#(
    parameter int TIMEOUT_W   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  ps2_clk_i,
    input  logic                  ps2_data_i,
    zx_ps2_keymatrix_if.master    rx_o
);

    localparam logic [TIMEOUT_W-1:0] WD_ONE = TIMEOUT_W'(1);

    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   clk_prev_q;
    logic                   clk_s, data_s, fall;

    rx_state_e              state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   parity_q, parity_d;
    logic [TIMEOUT_W-1:0]   wdog_q, wdog_d;
    logic [7:0]             byte_q, byte_d;
    logic                   valid_q, valid_d;

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];
    assign fall   = clk_prev_q & ~clk_s;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
            state_q     <= RX_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            wdog_q      <= '0;
            byte_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
            clk_prev_q  <= clk_s;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            wdog_q      <= wdog_d;
            byte_q      <= byte_d;
            valid_q     <= valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        wdog_d    = '0;
        byte_d    = byte_q;
        valid_d   = 1'b0;
        if (state_q != RX_IDLE) begin
            wdog_d = fall ? '0 : wdog_q + WD_ONE;
        end
        case (state_q)
            RX_IDLE: begin
                if (fall && !data_s) begin
                    state_d   = RX_DATA;
                    bit_cnt_d = '0;
                end
            end
            RX_DATA: begin
                if (fall) begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
                end
            end
            RX_PARITY: begin
                if (fall) begin
                    parity_d = data_s;
                    state_d  = RX_STOP;
                end
            end
            RX_STOP: begin
                if (fall) begin
                    state_d = RX_IDLE;
                    if (data_s && (^{shift_q, parity_q})) begin
                        valid_d = 1'b1;
                        byte_d  = shift_q;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
        // A stalled frame is abandoned; the partial byte is simply never emitted.
        if (state_q != RX_IDLE && !fall && (&wdog_q)) begin
            state_d = RX_IDLE;
        end
    end

    assign rx_o.rx_byte  = byte_q;
    assign rx_o.rx_valid = valid_q;

endmodule

// File: rtl/zx_ps2_keymatrix.sv
// PS/2 set-2 keyboard to ZX Spectrum 8x5 key matrix, plus host Fn and
// modifier levels. key_data is the registered, active-low column read.
module zx_ps2_keymatrix
    import zx_kbd_pkg::*;
#(
    parameter int TIMEOUT_W   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_kbd_clk,
    input  logic        ps2_kbd_data,
    input  logic [15:0] addr,
    output logic [4:0]  key_data,
    output logic [11:1] Fn,
    output logic [2:0]  mod
);

    zx_ps2_keymatrix_if rx_if ();

    ps2_rx #(.TIMEOUT_W(TIMEOUT_W), .SYNC_STAGES(SYNC_STAGES)) u_rx (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ps2_clk_i  (ps2_kbd_clk),
        .ps2_data_i (ps2_kbd_data),
        .rx_o       (rx_if)
    );

    logic            ext_q, ext_d, rel_q, rel_d;
    logic [7:0][4:0] base_q, base_d, eff;
    // Combo bits: 0 Left, 1 Down, 2 Up, 3 Right, 4 Backspace.
    logic [4:0]      combo_q, combo_d;
    logic [11:1]     fn_q, fn_d;
    logic [2:0]      mod_q, mod_d;
    logic [4:0]      kd_q, kd_d;
    key_pos_t        pos;
    logic [3:0]      fn_idx;
    logic            press;
    logic [7:0]      code;
    logic            unused_addr;

    assign unused_addr = ^addr[7:0];
    assign code        = rx_if.rx_byte;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ext_q   <= 1'b0;
            rel_q   <= 1'b0;
            base_q  <= '0;
            combo_q <= '0;
            fn_q    <= '0;
            mod_q   <= '0;
            kd_q    <= 5'b11111;
        end else begin
            ext_q   <= ext_d;
            rel_q   <= rel_d;
            base_q  <= base_d;
            combo_q <= combo_d;
            fn_q    <= fn_d;
            mod_q   <= mod_d;
            kd_q    <= kd_d;
        end
    end

    always_comb begin
        ext_d   = ext_q;
        rel_d   = rel_q;
        base_d  = base_q;
        combo_d = combo_q;
        fn_d    = fn_q;
        mod_d   = mod_q;
        pos     = sc_to_pos(ext_q, code);
        fn_idx  = sc_to_fn(ext_q, code);
        press   = ~rel_q;
        if (rx_if.rx_valid) begin
            if (code == SC_E0) begin
                ext_d = 1'b1;
            end else if (code == SC_F0) begin
                rel_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                rel_d = 1'b0;
                if (code == SC_ALT)                                        mod_d[0] = press;
                else if (code == SC_CTRL)                                  mod_d[1] = press;
                else if (!ext_q && (code == SC_LSHIFT || code == SC_RSHIFT)) mod_d[2] = press;
                else if (fn_idx != 4'd0)                                   fn_d[fn_idx] = press;
                else if (ext_q && code == SC_LEFT)                         combo_d[0] = press;
                else if (ext_q && code == SC_DOWN)                         combo_d[1] = press;
                else if (ext_q && code == SC_UP)                           combo_d[2] = press;
                else if (ext_q && code == SC_RIGHT)                        combo_d[3] = press;
                else if (!ext_q && code == SC_BKSP)                        combo_d[4] = press;
                else if (pos.valid)                                        base_d[pos.row][pos.col] = press;
            end
        end
    end

    // CS and SS are ORed in from every source so no single release can drop them.
    always_comb begin
        eff       = base_q;
        eff[0][0] = base_q[0][0] | (|combo_q) | mod_q[2];
        eff[7][1] = base_q[7][1] | mod_q[1];
        eff[3][4] = base_q[3][4] | combo_q[0];
        eff[4][4] = base_q[4][4] | combo_q[1];
        eff[4][3] = base_q[4][3] | combo_q[2];
        eff[4][2] = base_q[4][2] | combo_q[3];
        eff[4][0] = base_q[4][0] | combo_q[4];
    end

    always_comb begin
        kd_d = 5'b11111;
        for (int r = 0; r < 8; r++) begin
            if (!addr[8+r]) kd_d = kd_d & ~eff[r];
        end
    end

    assign key_data = kd_q;
    assign Fn       = fn_q;
    assign mod      = mod_q;

endmodule

// File: tb/tb_zx_ps2_keymatrix.sv
// Self-checking bench for zx_ps2_keymatrix: PS/2 frame driver, matrix probes
// checked against an expected-value queue, and a summary report.
module tb_zx_ps2_keymatrix;

  localparam int HALF = 4;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_kbd_clk = 1'b1;
  logic        ps2_kbd_data = 1'b1;
  logic [15:0] addr = 16'hFFFF;
  logic [4:0]  key_data;
  logic [11:1] Fn;
  logic [2:0]  mod;

  logic [4:0]  exp_q[$];
  logic [4:0]  exp_v;
  int          checks = 0;
  int          errors = 0;

  logic [7:0]  t_code [12] = '{8'h1C, 8'h1B, 8'h15, 8'h16, 8'h45, 8'h4D,
                               8'h5A, 8'h29, 8'h32, 8'h3A, 8'h1A, 8'h35};
  int          t_row  [12] = '{1, 1, 2, 3, 4, 5, 6, 7, 7, 7, 0, 5};
  int          t_col  [12] = '{0, 1, 0, 0, 0, 0, 0, 0, 4, 2, 1, 4};
  logic [4:0]  model_m [8];

  zx_ps2_keymatrix #(.TIMEOUT_W(16), .SYNC_STAGES(2)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ps2_kbd_clk  (ps2_kbd_clk),
    .ps2_kbd_data (ps2_kbd_data),
    .addr         (addr),
    .key_data     (key_data),
    .Fn           (Fn),
    .mod          (mod)
  );

  // clock / reset
  always #5 clk_sys = ~clk_sys;

  // driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_sys);
  endtask

  task automatic send_bit(input logic b);
    ps2_kbd_data = b;
    wait_cyc(HALF);
    ps2_kbd_clk = 1'b0;
    wait_cyc(HALF);
    ps2_kbd_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(~bad_stop);
    ps2_kbd_data = 1'b1;
    wait_cyc(3 * HALF);
  endtask

  task automatic key_make(input logic ext, input logic [7:0] c);
    if (ext) send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(c, 1'b0, 1'b0);
  endtask

  task automatic key_break(input logic ext, input logic [7:0] c);
    if (ext) send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(c, 1'b0, 1'b0);
  endtask

  // Drives a row select and queues the column result it must produce.
  task automatic probe(input logic [15:0] a, input logic [4:0] e);
    @(negedge clk_sys);
    addr = a;
    exp_q.push_back(e);
    @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    wait_cyc(4);
    @(negedge clk_sys);
    reset = 1'b0;
    probe(16'h00FE, 5'b11111);
    exp_v = exp_q.pop_front(); checks++;
    if (key_data !== exp_v) begin errors++; $display("FAIL reset_kd got=%b exp=%b", key_data, exp_v); end
    checks++;
    if (Fn !== 11'h000) begin errors++; $display("FAIL reset_fn got=%h exp=000", Fn); end
    checks++;
    if (mod !== 3'b000) begin errors++; $display("FAIL reset_mod got=%b exp=000", mod); end
  endtask

  task automatic test_make_break;
    key_make(1'b0, 8'h1C);
    probe(16'hFDFE, 5'b11110);
    exp_v = exp_q.pop_front(); checks++;
    if (key_data !== exp_v) begin errors++; $display("FAIL a_make got=%b exp=%b", key_data, exp_v); end
    probe(16'hFEFE, 5'b11111);
    exp_v = exp_q.pop_front(); checks++;
    if (key_data !== exp_v) begin errors++; $display("FAIL a_other_row got=%b exp=%b", key_data, exp_v); end
    key_make(1'b0, 8'h1C);
    key_break(1'b0, 8'h1C);
    probe(16'hFDFE, 5'b11111);
    exp_v = exp_q.pop_front(); checks++;
    if (key_data !== exp_v) begin errors++; $display("FAIL a_break got=%b exp=%b", key_data, exp_v); end
  endtask

  task automatic test_combo;
    key_make(1'b1, 8'h6B);
    probe(16'hFEFE, 5'b11110);
    exp_v = exp_q.pop_front(); checks++;
    if (key_data !== exp_v) begin errors++; $display("FAIL left_cs got=%b exp=%b", key_data, exp_v); end
    probe(16'hF7FE, 5'b01111);
    exp_v = exp_q.pop_front(); checks++;
    if (key_data !== exp_v) begin errors++; $display("FAIL left_5 got=%b exp=%b", key_data, exp_v); end
    key_make(1'b0, 8'h12);
    key_break(1'b1, 8'h6B);
    probe(16'hFEFE, 5'b11110);
    exp_v = exp_q.pop_front(); checks++;
    if (key_data !== exp_v) begin errors++; $display("FAIL shift_cs_held got=%b exp=%b", key_data, exp_v); end
    probe(16'hF7FE, 5'b11111);
    exp_v = exp_q.pop_front(); checks++;
    if (key_data !== exp_v) begin errors++; $display("FAIL left_5_released got=%b exp=%b", key_data, exp_v); end
    checks++;
    if (mod !== 3'b100) begin errors++; $display("FAIL shift_mod got=%b exp=100", mod); end
    key_break(1'b0, 8'h59);
    checks++;
    if (mod !== 3'b000) begin errors++; $display("FAIL rshift_clears got=%b exp=000", mod); end
    key_make(1'b0, 8'h66);
    key_make(1'b1, 8'h75);
    probe(16'hEFFE, 5'b10110);
    exp_v = exp_q.pop_front(); checks++;
    if (key_data !== exp_v) begin errors++; $display("FAIL bksp_up_row4 got=%b exp=%b", key_data, exp_v); end
    key_break(1'b0, 8'h66);
    key_break(1'b1, 8'h75);
    probe(16'hEEFE, 5'b11111);
    exp_v = exp_q.pop_front(); checks++;
    if (key_data !== exp_v) begin errors++; $display("FAIL combo_clear got=%b exp=%b", key_data, exp_v); end
  endtask

  task automatic test_fn_mod;
    key_make(1'b0, 8'h14);
    key_make(1'b0, 8'h78);
    checks++;
    if (mod !== 3'b010) begin errors++; $display("FAIL ctrl_mod got=%b exp=010", mod); end
    checks++;
    if (Fn !== 11'h400) begin errors++; $display("FAIL f11 got=%h exp=400", Fn); end
    probe(16'h7FFE, 5'b11101);
    exp_v = exp_q.pop_front(); checks++;
    if (key_data !== exp_v) begin errors++; $display("FAIL ctrl_ss got=%b exp=%b", key_data, exp_v); end
    key_break(1'b0, 8'h14);
    key_break(1'b0, 8'h78);
    checks++;
    if ({Fn, mod} !== 14'h0) begin errors++; $display("FAIL fn_mod_release got=%h/%b exp=000/000", Fn, mod); end
    key_make(1'b0, 8'h83);
    key_make(1'b1, 8'h11);
    checks++;
    if ({Fn, mod} !== {11'h040, 3'b001}) begin errors++; $display("FAIL f7_ralt got=%h/%b exp=040/001", Fn, mod); end
    key_break(1'b0, 8'h83);
    key_break(1'b1, 8'h11);
    probe(16'h7FFE, 5'b11111);
    exp_v = exp_q.pop_front(); checks++;
    if (key_data !== exp_v) begin errors++; $display("FAIL ss_release got=%b exp=%b", key_data, exp_v); end
  endtask

  task automatic test_bad_frame;
    send_frame(8'h1C, 1'b1, 1'b0);
    send_frame(8'h1D, 1'b0, 1'b1);
    probe(16'hF9FE, 5'b11111);
    exp_v = exp_q.pop_front(); checks++;
    if (key_data !== exp_v) begin errors++; $display("FAIL bad_dropped got=%b exp=%b", key_data, exp_v); end
    send_frame(8'h1B, 1'b0, 1'b0);
    probe(16'hFDFE, 5'b11101);
    exp_v = exp_q.pop_front(); checks++;
    if (key_data !== exp_v) begin errors++; $display("FAIL s_after_bad got=%b exp=%b", key_data, exp_v); end
    key_break(1'b0, 8'h1B);
  endtask

  task automatic test_watchdog;
    logic [7:0] b;
    b = 8'h1C;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    ps2_kbd_data = 1'b1;
    wait_cyc(65536 + 20);
    send_frame(8'h1C, 1'b0, 1'b0);
    probe(16'hFDFE, 5'b11110);
    exp_v = exp_q.pop_front(); checks++;
    if (key_data !== exp_v) begin errors++; $display("FAIL wdog_recover got=%b exp=%b", key_data, exp_v); end
    key_break(1'b0, 8'h1C);
  endtask

  task automatic test_reset_mid;
    logic [7:0] b;
    b = 8'h1B;
    key_make(1'b0, 8'h1C);
    key_make(1'b0, 8'h05);
    key_make(1'b0, 8'h11);
    checks++;
    if ({Fn, mod} !== {11'h001, 3'b001}) begin errors++; $display("FAIL held_before_reset got=%h/%b exp=001/001", Fn, mod); end
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(b[i]);
    ps2_kbd_data = 1'b1;
    @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    probe(16'h00FE, 5'b11111);
    exp_v = exp_q.pop_front(); checks++;
    if (key_data !== exp_v) begin errors++; $display("FAIL reset_mid_kd got=%b exp=%b", key_data, exp_v); end
    checks++;
    if ({Fn, mod} !== 14'h0) begin errors++; $display("FAIL reset_mid_fn_mod got=%h/%b exp=000/000", Fn, mod); end
    wait_cyc(4 * HALF);
    send_frame(8'h1B, 1'b0, 1'b0);
    probe(16'hFDFE, 5'b11101);
    exp_v = exp_q.pop_front(); checks++;
    if (key_data !== exp_v) begin errors++; $display("FAIL after_reset_frame got=%b exp=%b", key_data, exp_v); end
    key_break(1'b0, 8'h1B);
  endtask

  task automatic test_random;
    int         picks [3];
    logic [7:0] rm;
    logic [4:0] e;
    for (int it = 0; it < 3; it++) begin
      for (int r = 0; r < 8; r++) model_m[r] = 5'b00000;
      for (int k = 0; k < 3; k++) begin
        picks[k] = $urandom_range(0, 11);
        key_make(1'b0, t_code[picks[k]]);
        model_m[t_row[picks[k]]][t_col[picks[k]]] = 1'b1;
      end
      for (int p = 0; p < 4; p++) begin
        rm = 8'($urandom_range(0, 255));
        e = 5'b11111;
        for (int r = 0; r < 8; r++) if (!rm[r]) e = e & ~model_m[r];
        probe({rm, 8'hFE}, e);
        exp_v = exp_q.pop_front(); checks++;
        if (key_data !== exp_v) begin errors++; $display("FAIL random_probe rows=%b got=%b exp=%b", rm, key_data, exp_v); end
      end
      for (int k = 0; k < 3; k++) key_break(1'b0, t_code[picks[k]]);
      probe(16'h00FE, 5'b11111);
      exp_v = exp_q.pop_front(); checks++;
      if (key_data !== exp_v) begin errors++; $display("FAIL random_release got=%b exp=%b", key_data, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_combo();
    test_fn_mod();
    test_bad_frame();
    test_watchdog();
    test_reset_mid();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
